uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit path.
// Provides the byte width, the default FIFO depth and the handshake FSM state type.
// No ports; imported by sync_fifo and uart_tx_fifo.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic registered-pointer FIFO with occupancy count and a drop indication.
// Latency: a push is visible at o_rdata/o_count one cycle after the accepting edge.
// Backpressure: pushes while full are discarded and flagged on o_drop; pops while empty are ignored.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_wdata       write request and data
//   i_pop                 read request (advances the read pointer)
//   o_rdata               entry at the read pointer (combinational from registers)
//   o_full, o_empty       occupancy flags derived from the registered count
//   o_count               current occupancy, 0..DEPTH
//   o_drop                push requested while full during this cycle
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_pop,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // Acceptance uses the flags registered before the edge, so a same-cycle
  // pop never makes room for a push arriving while full.
  assign w_push_ok = i_push & ~w_full;
  assign w_pop_ok  = i_pop & ~w_empty;

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_drop  = i_push & w_full;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered transmit queue feeding a UART transmitter through a start/busy handshake.
// Latency: push at edge N into an empty idle queue pops at N+1; o_tx_start is high N+1..N+2.
// Backpressure: none toward the CPU; pushes while full are dropped and latched in o_overflow.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wr_en, i_wr_data    byte push from the CPU store path
//   o_full, o_empty       queue occupancy flags
//   o_count               queue occupancy
//   o_overflow, i_clr_ovf sticky drop flag and its clear
//   o_idle                queue empty and handshake FSM idle
//   o_sdata, o_tx_start   byte and one-cycle start strobe to the transmitter
//   i_tx_busy             transmitter busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [DEPTH_LOG2:0]    o_count,
  output logic                   o_overflow,
  input  logic                   i_clr_ovf,
  output logic                   o_idle,
  output logic [UART_DATA_W-1:0] o_sdata,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy
);

  tx_state_e              r_state;
  logic [UART_DATA_W-1:0] r_sdata;
  logic                   r_tx_start;
  logic                   r_overflow;

  logic [UART_DATA_W-1:0] w_rdata;
  logic                   w_empty;
  logic                   w_drop;
  logic                   w_pop;

  // The pop and the IDLE->START transition share one condition, so the
  // byte latched into r_sdata is always the one the FIFO just released.
  assign w_pop = (r_state == ST_IDLE) & ~w_empty & ~i_tx_busy;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (UART_DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr_en),
    .i_wdata (i_wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_count (o_count),
    .o_drop  (w_drop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_sdata    <= '0;
      r_tx_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_sdata    <= w_rdata;
            r_tx_start <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_WAIT_ACK;
        end
        // No timeout: a transmitter that never raises busy parks us here.
        ST_WAIT_ACK: begin
          if (i_tx_busy) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!i_tx_busy) r_state <= ST_IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;
  assign o_sdata    = r_sdata;
  assign o_tx_start = r_tx_start;
  assign o_idle     = w_empty & (r_state == ST_IDLE);

endmodule
